// File: rtl/line_fetcher.sv
// Burst-read initiator: requests an SDRAM burst into high RAM through memory_map, then
// replays high RAM port B as a valid/ready word stream with credit-based flow control.
module line_fetcher #(
  parameter int unsigned READ_LAT  = 1,
  parameter logic [1:0]  ACC_BURST = 2'b10
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [23:0] base_addr,
  input  logic [8:0]  len,
  output logic        busy,
  output logic        done,
  output logic [15:0] px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [31:0] mem_addr,
  output logic        mem_cs,
  output logic        mem_wr,
  output logic [1:0]  mem_acc,
  output logic [8:0]  mem_burst,
  output logic [31:0] mem_din,
  input  logic        mem_ack,
  output logic        mem_cpu_acc,
  output logic [8:0]  hr_addr,
  output logic [15:0] hr_din,
  output logic        hr_wr,
  input  logic [15:0] hr_dout
);

  localparam int unsigned Depth = READ_LAT + 1;
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StStream,
    StFin
  } state_e;

  state_e              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_mem_cs;
  logic [31:0]         r_mem_addr;
  logic [1:0]          r_mem_acc;
  logic [8:0]          r_mem_burst;
  logic [9:0]          r_rd_ptr;
  logic [8:0]          r_out_cnt;
  logic [READ_LAT-1:0] r_pipe;
  logic [15:0]         r_fifo [Depth];
  logic [PtrW-1:0]     r_wptr;
  logic [PtrW-1:0]     r_rptr;
  logic [CntW-1:0]     r_count;

  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic       w_credit;
  logic [2:0] w_inflight;
  logic [2:0] w_used;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      w_inflight = w_inflight + 3'(r_pipe[i]);
    end
  end

  // A pop in this cycle frees a slot, so it lends a credit to the same-cycle issue;
  // that keeps the stream bubble-free with only READ_LAT+1 words of buffering.
  assign w_pop    = (r_count != '0) && px_ready;
  assign w_push   = r_pipe[READ_LAT-1];
  assign w_used   = 3'(r_count) + w_inflight;
  assign w_credit = w_used < (3'(Depth) + 3'(w_pop));
  assign w_issue  = (r_state == StStream) && (r_rd_ptr <= {1'b0, r_mem_burst}) && w_credit;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_acc   <= ACC_BURST;
      r_mem_burst <= '0;
      r_rd_ptr    <= '0;
      r_out_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mem_addr  <= {8'h00, base_addr};
            r_mem_acc   <= ACC_BURST;
            r_mem_burst <= len;
            r_mem_cs    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StReq;
          end
        end
        StReq: begin
          r_mem_cs <= 1'b0;
          r_state  <= StWait;
        end
        StWait: begin
          r_rd_ptr  <= '0;
          r_out_cnt <= '0;
          if (mem_ack) begin
            r_state <= StStream;
          end
        end
        StStream: begin
          if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + 10'd1;
          end
          if (w_pop) begin
            r_out_cnt <= r_out_cnt + 9'd1;
            if (r_out_cnt == r_mem_burst) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StFin;
            end
          end
        end
        StFin: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_mem_cs <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  // Read-return pipeline and output FIFO.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pipe  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_issue;
      for (int i = 1; i < READ_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      if (w_push) begin
        r_fifo[r_wptr] <= hr_dout;
        r_wptr         <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign px_valid    = (r_count != '0);
  assign px_data     = r_fifo[r_rptr];
  assign mem_addr    = r_mem_addr;
  assign mem_cs      = r_mem_cs;
  assign mem_wr      = 1'b0;
  assign mem_acc     = r_mem_acc;
  assign mem_burst   = r_mem_burst;
  assign mem_din     = '0;
  assign mem_cpu_acc = 1'b0;
  assign hr_addr     = r_rd_ptr[8:0];
  assign hr_din      = '0;
  assign hr_wr       = 1'b0;

endmodule

// File: tb/tb_line_fetcher.sv
// Drives two fetchers (READ_LAT 1 and 2) with shared stimulus and checks each stream
// against the high-RAM contents, request handshake, timing and buffering bounds.
module tb_line_fetcher;

  localparam logic [1:0] AccBurst = 2'b10;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        start = 1'b0;
  logic        px_ready = 1'b0;
  logic        mem_ack = 1'b0;
  logic [23:0] base_addr = '0;
  logic [8:0]  len = '0;

  logic        busy [2];
  logic        done [2];
  logic        px_valid [2];
  logic        mem_cs [2];
  logic        mem_wr [2];
  logic        mem_cpu_acc [2];
  logic        hr_wr [2];
  logic [15:0] px_data [2];
  logic [15:0] hr_din [2];
  logic [15:0] hr_dout [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_din [2];
  logic [1:0]  mem_acc [2];
  logic [8:0]  mem_burst [2];
  logic [8:0]  hr_addr [2];

  logic [15:0] ram [512];
  logic [15:0] rd1, rd2a, rd2b;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit stream_on = 1'b0;
  int cur_len = 0;
  int got_cnt [2];
  int done_cnt [2];
  int done_cyc [2];
  int cs_cnt [2];
  int max_hr [2];
  bit prev_stall [2];
  logic [15:0] prev_data [2];

  line_fetcher #(.READ_LAT(1)) u_dut0 (
    .clk(clk), .res(res), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy[0]), .done(done[0]), .px_data(px_data[0]), .px_valid(px_valid[0]),
    .px_ready(px_ready), .mem_addr(mem_addr[0]), .mem_cs(mem_cs[0]), .mem_wr(mem_wr[0]),
    .mem_acc(mem_acc[0]), .mem_burst(mem_burst[0]), .mem_din(mem_din[0]),
    .mem_ack(mem_ack), .mem_cpu_acc(mem_cpu_acc[0]), .hr_addr(hr_addr[0]),
    .hr_din(hr_din[0]), .hr_wr(hr_wr[0]), .hr_dout(hr_dout[0])
  );

  line_fetcher #(.READ_LAT(2)) u_dut1 (
    .clk(clk), .res(res), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy[1]), .done(done[1]), .px_data(px_data[1]), .px_valid(px_valid[1]),
    .px_ready(px_ready), .mem_addr(mem_addr[1]), .mem_cs(mem_cs[1]), .mem_wr(mem_wr[1]),
    .mem_acc(mem_acc[1]), .mem_burst(mem_burst[1]), .mem_din(mem_din[1]),
    .mem_ack(mem_ack), .mem_cpu_acc(mem_cpu_acc[1]), .hr_addr(hr_addr[1]),
    .hr_din(hr_din[1]), .hr_wr(hr_wr[1]), .hr_dout(hr_dout[1])
  );

  assign hr_dout[0] = rd1;
  assign hr_dout[1] = rd2b;

  always #5 clk = ~clk;

  // High RAM port B with one and two cycles of read latency.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd1  <= ram[hr_addr[0]];
    rd2a <= ram[hr_addr[1]];
    rd2b <= rd2a;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq({tag, "_busy"}, 32'(busy[k]), 0);
      check_eq({tag, "_done"}, 32'(done[k]), 0);
      check_eq({tag, "_valid"}, 32'(px_valid[k]), 0);
      check_eq({tag, "_data"}, 32'(px_data[k]), 0);
      check_eq({tag, "_cs"}, 32'(mem_cs[k]), 0);
      check_eq({tag, "_addr"}, mem_addr[k], 0);
      check_eq({tag, "_burst"}, 32'(mem_burst[k]), 0);
      check_eq({tag, "_acc"}, 32'(mem_acc[k]), 32'(AccBurst));
      check_eq({tag, "_hraddr"}, 32'(hr_addr[k]), 0);
      check_eq({tag, "_ties"}, {mem_wr[k], mem_cpu_acc[k], hr_wr[k]} | mem_din[k] | hr_din[k],
               0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (mem_cs[k]) cs_cnt[k]++;
        if (done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
          check_eq("busy_at_done", 32'(busy[k]), 0);
        end
        if (stream_on) begin
          if (prev_stall[k]) begin
            check_eq("stall_valid", 32'(px_valid[k]), 1);
            check_eq("stall_data", 32'(px_data[k]), 32'(prev_data[k]));
          end
          if (cur_len < 511)
            check_eq("buffered", ((int'(hr_addr[k]) - got_cnt[k]) <= k + 2) ? 1 : 0, 1);
          if (int'(hr_addr[k]) > max_hr[k]) max_hr[k] = int'(hr_addr[k]);
          if (px_valid[k] && px_ready) begin
            if (got_cnt[k] <= cur_len) check_eq("word", 32'(px_data[k]), 32'(ram[got_cnt[k]]));
            else check_eq("overrun", got_cnt[k], cur_len);
            got_cnt[k]++;
          end
          prev_stall[k] = px_valid[k] && !px_ready;
          prev_data[k]  = px_data[k];
        end
      end
    end
  end

  // rmode: 0 ready always high, 1 random 50%, 2 low for 10 cycles after the 2nd word.
  task automatic run_txn(input logic [23:0] b, input int l, input int rmode, input int ack_dly,
                         input bit extra, input int abort_at, input bit seq_data);
    logic [31:0] exp_addr;
    int a_cyc, n, bp_left;
    bit bp_used;
    exp_addr = {8'h00, b};
    for (int i = 0; i < 512; i++) ram[i] = seq_data ? 16'(16'hA000 + i) : 16'($urandom);
    cur_len = l;
    for (int k = 0; k < 2; k++) begin
      got_cnt[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0; cs_cnt[k] = 0; max_hr[k] = 0;
      prev_stall[k] = 1'b0;
    end
    stream_on = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    base_addr = b; len = 9'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 24'($urandom); len = 9'($urandom);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq("req_cs", 32'(mem_cs[k]), 1);
      check_eq("req_busy", 32'(busy[k]), 1);
      check_eq("req_addr", mem_addr[k], exp_addr);
      check_eq("req_burst", 32'(mem_burst[k]), 32'(l));
      check_eq("req_acc", 32'(mem_acc[k]), 32'(AccBurst));
    end
    for (int i = 0; i < ack_dly; i++) begin
      @(posedge clk); #1;
      start = extra && (i == 1);
      if (start) begin base_addr = 24'($urandom); len = 9'($urandom); end
    end
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b1; a_cyc = cyc;
    n = 0; bp_left = 0; bp_used = 1'b0;
    while (!(done_cnt[0] != 0 && done_cnt[1] != 0) && n < 5000) begin
      @(posedge clk); #1;
      if (n == 0) begin mem_ack = 1'b0; stream_on = 1'b1; end
      start = extra && (n == 2);
      if (start) begin base_addr = 24'($urandom); len = 9'($urandom); end
      if (rmode == 0) px_ready = 1'b1;
      else if (rmode == 1) px_ready = 1'($urandom_range(0, 1));
      else begin
        if (!bp_used && got_cnt[0] >= 2) begin bp_used = 1'b1; bp_left = 10; end
        px_ready = (bp_left == 0);
        if (bp_left > 0) bp_left--;
      end
      if (abort_at != 0 && n == abort_at) begin
        #2 res = 1'b1;
        #1 mon_en = 1'b0; stream_on = 1'b0; start = 1'b0;
        check_reset_vals("rst_mid");
        @(posedge clk); #1 res = 1'b0;
        return;
      end
      n++;
    end
    start = 1'b0;
    @(negedge clk);
    mon_en = 1'b0; stream_on = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_eq("word_count", got_cnt[k], l + 1);
      check_eq("done_count", done_cnt[k], 1);
      check_eq("cs_count", cs_cnt[k], 1);
      check_eq("held_addr", mem_addr[k], exp_addr);
      check_eq("held_burst", 32'(mem_burst[k]), 32'(l));
      check_eq("idle_busy", 32'(busy[k]), 0);
      if (rmode == 0) check_eq("done_latency", done_cyc[k] - a_cyc, 3 + (k + 1) + l);
      if (l == 511) check_eq("hr_addr_max", max_hr[k], 511);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = '0;
    #1 res = 1'b1;
    repeat (2) @(posedge clk);
    #2 check_reset_vals("reset");
    @(posedge clk); #1 res = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq("idle_ack_busy", 32'(busy[k]), 0);
      check_eq("idle_ack_cs", 32'(mem_cs[k]), 0);
    end

    run_txn(24'h001000, 3, 0, 20, 1'b0, 0, 1'b1);
    run_txn(24'(($urandom)), 0, 0, 5, 1'b0, 0, 1'b0);
    run_txn(24'(($urandom)), 511, 1, 7, 1'b0, 0, 1'b0);
    run_txn(24'(($urandom)), 15, 2, 4, 1'b0, 0, 1'b0);
    run_txn(24'h00BEEF, 7, 0, 6, 1'b1, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_txn(24'($urandom), int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
              int'($urandom_range(3, 12)), 1'($urandom_range(0, 1)), 0, 1'b0);
    end
    run_txn(24'($urandom), 100, 1, 5, 1'b0, 30, 1'b0);
    run_txn(24'h00ABCD, 9, 0, 4, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_fetcher.md
# line_fetcher

Burst-read initiator for the memory-map request port. On a `start` pulse it issues one `ACC_BURST` read of `len+1` 16-bit words from SDRAM into high RAM, then reads high RAM back through the external port B and streams the words out on a valid/ready interface. It sits beside `memory_map`, driving its `cs/wr/acc/burst/addr` inputs, watching its `ack`, and owning the `ext_high_ram_*` port.

## Interface
- `READ_LAT`, default 1: high-RAM port-B read latency in cycles (address in to `q_b` valid); legal values 1..2.
- `clk`, in, 1: sole clock.
- `res`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request; sampled only in IDLE.
- `base_addr`, in, 24: SDRAM word address; captured on `start`.
- `len`, in, 9: word count minus one (0..511); captured on `start`.
- `busy`, out, 1: high from the cycle after an accepted `start` through the cycle before `done`.
- `done`, out, 1: one-cycle pulse after the last word handshake.
- `px_data`, out, 16: stream data.
- `px_valid`, out, 1: stream valid.
- `px_ready`, in, 1: stream ready.
- `mem_addr`, out, 32: `{8'h00, base_addr}`.
- `mem_cs`, out, 1: one-cycle request strobe.
- `mem_wr`, out, 1: tied 0.
- `mem_acc`, out, 2: `ACC_BURST` from `memory_access.vh`.
- `mem_burst`, out, 9: captured `len`.
- `mem_din`, out, 32: tied 0.
- `mem_ack`, in, 1: transaction-complete pulse.
- `mem_cpu_acc`, out, 1: tied 0, which selects high RAM.
- `hr_addr`, out, 9: high-RAM port-B address.
- `hr_din`, out, 16: tied 0.
- `hr_wr`, out, 1: tied 0.
- `hr_dout`, in, 16: high-RAM port-B read data.

## Operation
- **States:** IDLE, REQ, WAIT, STREAM, FIN.
- **IDLE:**
  - `start` captures `base_addr` and `len` and moves to REQ.
  - Without `start`, the block stays in IDLE.
  - `mem_ack` is ignored.
- **REQ:**
  - `mem_cs` = 1 for exactly this one cycle, then WAIT.
  - `mem_addr`, `mem_acc` and `mem_burst` are registered and stay stable from REQ until the block leaves WAIT. They hold their values afterwards as well.
- **WAIT:**
  - Hold until `mem_ack` = 1, then go to STREAM.
  - Clear the issue counter `rd_ptr` and the output counter `out_cnt`.
- **STREAM:**
  - Each cycle, drive `hr_addr` = `rd_ptr`. Increment `rd_ptr` when both hold:
    - `rd_ptr <= len`, using a 10-bit compare so that `len` = 511 terminates.
    - Credits are available.
  - Issued reads enter a `READ_LAT`-deep valid shift pipeline. On exit, `hr_dout` is written into an output FIFO of depth `READ_LAT+1`.
  - A credit exists when FIFO occupancy plus in-flight reads is below `READ_LAT+1`. No word is ever dropped under backpressure.
  - `px_valid` = FIFO non-empty; `px_data` = FIFO head.
  - `out_cnt` increments on each `px_valid & px_ready`.
  - The handshake at `out_cnt == len` moves the block to FIN.
- **FIN:** `done` = 1 and `busy` = 0 for one cycle, then IDLE.
- **`start` outside IDLE:** ignored. No queueing.
- **Reset:** `res` is shared with `memory_map`, so no orphan transaction survives reset. A `mem_ack` arriving in IDLE is ignored.
- **Output reset values:** every output is 0 except `mem_acc`, which resets to `ACC_BURST`. The FIFO, pipeline and counters are cleared.

## Timing
- **Request timing:**
  - `start` in cycle t puts the block in REQ in t+1, with `mem_cs` high in t+1 and `busy` high from t+1.
  - WAIT begins at t+2.
- **Stream startup:**
  - `mem_ack` seen in cycle a puts the block in STREAM in a+1, with the first `hr_addr` = 0 issued in a+1.
  - With `READ_LAT` = 1, first `px_valid` = a+3: the read returns at a+2 and the FIFO registers it.
- **Throughput:** with `px_ready` held high, one word per cycle with no bubbles. Last handshake at a+3+`len`; `done` at a+4+`len`.
- **Backpressure:**
  - While `px_ready` = 0, `px_valid` and `px_data` hold stable.
  - Issue stalls once credits are exhausted.
  - Resuming `px_ready` restores one word per cycle immediately.
- **Simultaneous read and write:** a FIFO read and write in the same cycle are both accepted.

## Test plan
- **Basic 4-word burst:** `base_addr`=24'h001000, `len`=3; `mem_ack` 20 cycles after `mem_cs`; high RAM holds 16'hA000..A003.
  - `mem_cs` pulses 1 cycle with `mem_addr`=32'h00001000, `mem_burst`=3, `mem_acc`=`ACC_BURST`.
  - Stream outputs A000, A001, A002, A003 in consecutive cycles.
  - `done` one cycle after A003.
- **Single word:** `len`=0 with `READ_LAT`=1 and 2 -> exactly one word, `done` at a+4 or a+5 respectively.
- **Full burst:** `len`=511, random `px_ready` (50%) -> 512 words in address order, none duplicated or lost, and the `hr_addr` maximum is 511.
- **Backpressure:** `px_ready` low for 10 cycles starting after the 2nd word -> `px_data` is stable while low, and no more than `READ_LAT+1` words are buffered.
- **Ignored starts:** a second `start` during WAIT and during STREAM -> no extra `mem_cs`, and the captured `len` and `base_addr` are unchanged.
- **Reset mid-operation:** `res` asserted mid-STREAM -> all outputs return to reset values asynchronously; a following `start` completes a normal transaction.
